elixirchip_es1_spu_sra_arbiter: RTL and testbench

Round-robin scheduler that shares one `elixirchip_es1_spu_op_sra` arithmetic-right-shift unit between `NUM_REQ` requesters inside the SPU.
- Each request carries a shift amount and a data word.
- Accepted requests are registered and issued to the shift unit, one per enabled cycle.
- A tag pipeline runs in step with the shift unit and returns each result on one shared output bus, with the ID of the requester that issued it.
- The block sits between the SPU instruction lanes and a single shared shifter instance, which it instantiates internally.

---
 rtl/elixirchip_es1_spu_sra_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_elixirchip_es1_spu_sra_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elixirchip_es1_spu_sra_arbiter.sv
// Round-robin arbiter sharing one arithmetic-right-shift unit between NUM_REQ
// requesters; a tag pipeline returns each result with its requester ID.

module elixirchip_es1_spu_op_sra #(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter int    SHIFT_BITS = 4,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic                  s_clear,
  input  logic                  s_valid,
  input  logic [SHIFT_BITS-1:0] s_shift,
  input  logic [DATA_BITS-1:0]  s_data,
  output logic [DATA_BITS-1:0]  m_data
);

  // Debug builds keep the last operand result in idle stages instead of zeroing.
  localparam bit HOLD_IDLE = (DEBUG == "true") || ((SIMULATION == "true") && (DEVICE != "RTL"));

  logic [DATA_BITS-1:0] shifted;
  assign shifted = $signed(s_data) >>> s_shift;

  generate
    if (LATENCY == 0) begin : g_comb
      assign m_data = (s_clear && !s_valid && !HOLD_IDLE) ? '0 : shifted;
    end else begin : g_pipe
      logic [DATA_BITS-1:0] stage_q [LATENCY];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
        end else if (cke) begin
          if (s_valid) begin
            stage_q[0] <= shifted;
          end else if (s_clear && !HOLD_IDLE) begin
            stage_q[0] <= '0;
          end
          for (int k = 1; k < LATENCY; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign m_data = stage_q[LATENCY-1];
    end
  endgenerate

endmodule

module elixirchip_es1_spu_sra_arbiter #(
  parameter int    NUM_REQ    = 4,
  parameter int    ID_BITS    = $clog2(NUM_REQ),
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter int    MAX_SHIFT  = DATA_BITS,
  parameter int    SHIFT_BITS = $clog2(MAX_SHIFT + 1),
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*SHIFT_BITS-1:0] s_shift,
  input  logic [NUM_REQ*DATA_BITS-1:0]  s_data,
  input  logic                          s_flush,
  output logic                          m_valid,
  output logic [ID_BITS-1:0]            m_id,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          busy
);

  // Handshake: a request transfers on s_valid[i] & s_ready[i]; s_valid and its
  // operands are held by the requester until accepted and never depend on
  // s_ready. Results have no backpressure: m_valid is high for exactly one
  // enabled cycle per accepted request.

  logic [ID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_BITS-1:0]    grant_id;
  logic                  grant_found;
  logic                  take_ok;
  logic                  accept;
  logic [SHIFT_BITS-1:0] sel_shift, sel_shift_sat;
  logic [DATA_BITS-1:0]  sel_data;

  logic                  iss_valid_q, iss_valid_d;
  logic [ID_BITS-1:0]    iss_id_q, iss_id_d;
  logic [SHIFT_BITS-1:0] iss_shift_q, iss_shift_d;
  logic [DATA_BITS-1:0]  iss_data_q, iss_data_d;

  logic                  tag_last_valid;
  logic [ID_BITS-1:0]    tag_last_id;
  logic                  tags_busy;
  logic [DATA_BITS-1:0]  op_out;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && s_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant[(int'(rr_ptr_q) + k) % NUM_REQ] = 1'b1;
        grant_id = ID_BITS'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign take_ok = cke & ~s_flush & reset_n;
  assign s_ready = take_ok ? grant : '0;
  assign accept  = take_ok & grant_found;

  assign sel_shift     = s_shift[int'(grant_id)*SHIFT_BITS +: SHIFT_BITS];
  assign sel_data      = s_data[int'(grant_id)*DATA_BITS +: DATA_BITS];
  assign sel_shift_sat = (sel_shift > SHIFT_BITS'(MAX_SHIFT)) ? SHIFT_BITS'(MAX_SHIFT) : sel_shift;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    iss_valid_d = iss_valid_q;
    iss_id_d    = iss_id_q;
    iss_shift_d = iss_shift_q;
    iss_data_d  = iss_data_q;
    if (cke) begin
      if (s_flush) begin
        iss_valid_d = 1'b0;
      end else begin
        iss_valid_d = accept;
        if (accept) begin
          iss_id_d    = grant_id;
          iss_shift_d = sel_shift_sat;
          iss_data_d  = sel_data;
          rr_ptr_d    = (grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_id_q    <= '0;
      iss_shift_q <= '0;
      iss_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q    <= iss_id_d;
      iss_shift_q <= iss_shift_d;
      iss_data_q  <= iss_data_d;
    end
  end

  elixirchip_es1_spu_op_sra #(
    .LATENCY    (LATENCY),
    .DATA_BITS  (DATA_BITS),
    .SHIFT_BITS (SHIFT_BITS),
    .DEVICE     (DEVICE),
    .SIMULATION (SIMULATION),
    .DEBUG      (DEBUG)
  ) u_sra (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .s_clear (~iss_valid_q),
    .s_valid (iss_valid_q),
    .s_shift (iss_shift_q),
    .s_data  (iss_data_q),
    .m_data  (op_out)
  );

  // Tags march in lockstep with the shifter stages so the ID lines up with its data.
  generate
    if (LATENCY == 0) begin : g_tag_none
      assign tag_last_valid = iss_valid_q;
      assign tag_last_id    = iss_id_q;
      assign tags_busy      = 1'b0;
    end else begin : g_tag_pipe
      logic [LATENCY-1:0] tag_valid_q;
      logic [ID_BITS-1:0] tag_id_q [LATENCY];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          tag_valid_q <= '0;
          for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= '0;
        end else if (cke) begin
          tag_valid_q[0] <= s_flush ? 1'b0 : iss_valid_q;
          tag_id_q[0]    <= iss_id_q;
          for (int k = 1; k < LATENCY; k++) begin
            tag_valid_q[k] <= s_flush ? 1'b0 : tag_valid_q[k-1];
            tag_id_q[k]    <= tag_id_q[k-1];
          end
        end
      end

      assign tag_last_valid = tag_valid_q[LATENCY-1];
      assign tag_last_id    = tag_id_q[LATENCY-1];
      assign tags_busy      = |tag_valid_q;
    end
  endgenerate

  assign m_valid = tag_last_valid & cke;
  assign m_id    = tag_last_id;
  assign m_data  = m_valid ? op_out : '0;
  assign busy    = iss_valid_q | tags_busy;

endmodule

// File: tb/tb_elixirchip_es1_spu_sra_arbiter.sv
// Bench for the SRA arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_elixirchip_es1_spu_sra_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ID_BITS    = 2;
  localparam int LATENCY    = 1;
  localparam int DATA_BITS  = 8;
  localparam int MAX_SHIFT  = 8;
  localparam int SHIFT_BITS = 4;
  localparam int EW         = 32 + ID_BITS + DATA_BITS;

  logic                          clk;
  logic                          reset_n;
  logic                          cke;
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ-1:0]            s_ready;
  logic [NUM_REQ*SHIFT_BITS-1:0] s_shift;
  logic [NUM_REQ*DATA_BITS-1:0]  s_data;
  logic                          s_flush;
  logic                          m_valid;
  logic [ID_BITS-1:0]            m_id;
  logic [DATA_BITS-1:0]          m_data;
  logic                          busy;

  elixirchip_es1_spu_sra_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .LATENCY   (LATENCY),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_shift (s_shift),
    .s_data  (s_data),
    .s_flush (s_flush),
    .m_valid (m_valid),
    .m_id    (m_id),
    .m_data  (m_data),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus state (main process only) ----------------
  logic [NUM_REQ-1:0]    pend;
  logic [SHIFT_BITS-1:0] pshift [NUM_REQ];
  logic [DATA_BITS-1:0]  pdata  [NUM_REQ];
  logic                  cke_b;
  logic                  flush_b;
  int                    n_chk_d, n_pass_d;

  // ---------------- model state (compare process only) ----------------
  logic [EW-1:0] exp_q[$];
  int            rr_m;
  int            ecnt;
  int            last_taken;
  int            n_chk_m, n_pass_m;

  initial begin
    rr_m = 0; ecnt = 0; last_taken = -1; n_chk_m = 0; n_pass_m = 0;
  end

  // Floor division by 2**min(sh, MAX_SHIFT) of the two's-complement value.
  function automatic logic [DATA_BITS-1:0] sra_ref(input logic [DATA_BITS-1:0] d, input int sh);
    int s, v, p, q;
    s = (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
    v = int'(d) - (d[DATA_BITS-1] ? (1 << DATA_BITS) : 0);
    p = 1 << s;
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
    return DATA_BITS'(q);
  endfunction

  task automatic chk_m(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk_m++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass_m++;
  endtask

  task automatic chk_d(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk_d++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass_d++;
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : cmp
    int                 gid;
    logic [NUM_REQ-1:0] er;
    logic               emv;
    logic [EW-1:0]      fr;
    if (!reset_n) begin
      chk_m("rst_s_ready", 32'(s_ready), 32'd0);
      chk_m("rst_m_valid", 32'(m_valid), 32'd0);
      chk_m("rst_m_id", 32'(m_id), 32'd0);
      chk_m("rst_m_data", 32'(m_data), 32'd0);
      chk_m("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      rr_m = 0;
      last_taken = -1;
    end else begin
      gid = -1;
      if (cke && !s_flush) begin
        for (int k = 0; k < NUM_REQ; k++)
          if (gid < 0 && s_valid[(rr_m + k) % NUM_REQ]) gid = (rr_m + k) % NUM_REQ;
      end
      er = '0;
      if (gid >= 0) er[gid] = 1'b1;
      fr = '0;
      if (exp_q.size() > 0) fr = exp_q[0];
      emv = cke && (exp_q.size() > 0) && (fr[EW-1 -: 32] == 32'(ecnt));
      chk_m("s_ready", 32'(s_ready), 32'(er));
      chk_m("m_valid", 32'(m_valid), 32'(emv));
      chk_m("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (emv) begin
        chk_m("m_id", 32'(m_id), 32'(fr[ID_BITS+DATA_BITS-1 -: ID_BITS]));
        chk_m("m_data", 32'(m_data), 32'(fr[DATA_BITS-1:0]));
      end else begin
        chk_m("m_data_idle", 32'(m_data), 32'd0);
      end
      last_taken = -1;
      if (cke) begin
        if (emv) void'(exp_q.pop_front());
        if (s_flush) begin
          exp_q.delete();
        end else if (gid >= 0) begin
          exp_q.push_back({32'(ecnt + 1 + LATENCY), ID_BITS'(gid),
                           sra_ref(s_data[gid*DATA_BITS +: DATA_BITS],
                                   int'(s_shift[gid*SHIFT_BITS +: SHIFT_BITS]))});
          rr_m = (gid + 1) % NUM_REQ;
          last_taken = gid;
        end
        ecnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      s_valid[i] = pend[i];
      s_shift[i*SHIFT_BITS +: SHIFT_BITS] = pshift[i];
      s_data[i*DATA_BITS +: DATA_BITS]    = pdata[i];
    end
    cke     = cke_b;
    s_flush = flush_b;
  endtask

  task automatic req(input int i, input logic [DATA_BITS-1:0] d, input logic [SHIFT_BITS-1:0] sh);
    pend[i]   = 1'b1;
    pdata[i]  = d;
    pshift[i] = sh;
  endtask

  // mode 0: directed, 1: random traffic, 2: every requester held valid
  task automatic tick(input int mode);
    @(posedge clk);
    if (last_taken >= 0) pend[last_taken] = 1'b0;
    if (mode == 1) begin
      cke_b   = ($urandom_range(0, 9) != 0);
      flush_b = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          req(i, DATA_BITS'($urandom), SHIFT_BITS'($urandom_range(0, 15)));
    end else if (mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i]) req(i, DATA_BITS'($urandom), SHIFT_BITS'($urandom_range(0, 15)));
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    pend    = '0;
    flush_b = 1'b0;
    cke_b   = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic sat_case(input logic [DATA_BITS-1:0] d, input logic [SHIFT_BITS-1:0] sh,
                          input logic [DATA_BITS-1:0] exp, input string name);
    req(0, d, sh);
    tick(0);
    tick(0);
    tick(0);
    #1;
    chk_d({name, "_valid"}, 32'(m_valid), 32'd1);
    chk_d(name, 32'(m_data), 32'(exp));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NUM_REQ-1:0] e_rdy;
    n_chk_d = 0; n_pass_d = 0;
    reset_n = 1'b0;
    cke_b   = 1'b1;
    flush_b = 1'b0;
    pend    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pshift[i] = '0;
      pdata[i]  = '0;
    end
    drive();
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk_d("post_rst_m_valid", 32'(m_valid), 32'd0);
    chk_d("post_rst_m_data", 32'(m_data), 32'd0);
    chk_d("post_rst_busy", 32'(busy), 32'd0);

    // single request from requester 2
    req(2, 8'h90, 4'd3);
    tick(0);
    #1;
    chk_d("single_ready", 32'(s_ready), 32'h4);
    tick(0);
    tick(0);
    #1;
    chk_d("single_m_valid", 32'(m_valid), 32'd1);
    chk_d("single_m_id", 32'(m_id), 32'd2);
    chk_d("single_m_data", 32'(m_data), 32'hF2);

    // saturating shifts
    sat_case(8'h80, 4'd15, 8'hFF, "sat_80_15");
    sat_case(8'h7F, 4'd8, 8'h00, "sat_7f_8");
    sat_case(8'h81, 4'd0, 8'h81, "sat_81_0");

    // all four held valid: strict rotation, gapless results at latency 2
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(2);
      #1;
      e_rdy = '0;
      e_rdy[k % NUM_REQ] = 1'b1;
      chk_d("rot_ready", 32'(s_ready), 32'(e_rdy));
      if (k >= 2) begin
        chk_d("rot_m_valid", 32'(m_valid), 32'd1);
        chk_d("rot_m_id", 32'(m_id), 32'((k - 2) % NUM_REQ));
      end
    end

    // flush one cycle after two acceptances
    do_reset();
    req(0, 8'h40, 4'd1);
    req(1, 8'hC0, 4'd2);
    tick(0);
    tick(0);
    flush_b = 1'b1;
    req(3, 8'hF0, 4'd4);
    tick(0);
    #1;
    chk_d("flush_ready", 32'(s_ready), 32'd0);
    flush_b = 1'b0;
    tick(0);
    #1;
    chk_d("post_flush_ready", 32'(s_ready), 32'h8);
    chk_d("post_flush_busy", 32'(busy), 32'd0);
    chk_d("post_flush_m_valid", 32'(m_valid), 32'd0);
    tick(0);
    #1;
    chk_d("post_flush_m_valid2", 32'(m_valid), 32'd0);
    tick(0);
    #1;
    chk_d("pending_result_valid", 32'(m_valid), 32'd1);
    chk_d("pending_result_id", 32'(m_id), 32'd3);
    chk_d("pending_result_data", 32'(m_data), 32'hFF);

    // asynchronous reset with two results in flight
    do_reset();
    req(1, 8'h11, 4'd1);
    req(2, 8'h22, 4'd1);
    tick(0);
    tick(0);
    tick(0);
    #1;
    chk_d("inflight_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_d("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk_d("async_rst_m_data", 32'(m_data), 32'd0);
    chk_d("async_rst_m_id", 32'(m_id), 32'd0);
    chk_d("async_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) req(i, 8'(8'h30 + i), 4'(i));
    drive();
    #1;
    chk_d("async_rst_ready", 32'(s_ready), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk_d("release_ready", 32'(s_ready), 32'h1);
    chk_d("release_m_valid", 32'(m_valid), 32'd0);
    tick(0);
    #1;
    chk_d("release_m_valid2", 32'(m_valid), 32'd0);
    chk_d("release_ready2", 32'(s_ready), 32'h2);
    tick(0);
    tick(0);

    // randomized traffic with cke ~90% high and occasional flush
    for (int n = 0; n < 3000; n++) tick(1);

    // drain
    @(posedge clk);
    #1;
    cke_b   = 1'b1;
    flush_b = 1'b0;
    pend    = '0;
    drive();
    repeat (8) tick(0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass_m + n_pass_d, n_chk_m + n_chk_d);
    $finish;
  end

endmodule
